mii_nibble_rx: RTL
==================

MII_NIBBLE_RX -- requirements
Module: mii_nibble_rx

Interface
REQ-001 SHALL have parameter P_MIN_PRE, default 4: minimum count of 0x5 preamble nibbles required before SFD.
REQ-002 SHALL have parameter P_MAX_BYTES, default 1522: maximum bytes per frame, counted after SFD and including FCS.
REQ-003 SHALL have port clk  in  1  single clock for all logic, sampled on the rising edge.
REQ-004 SHALL have port rst  in  1  synchronous active-high reset.
REQ-005 SHALL have port mii_rx_dv  in  1  PHY receive data valid.
REQ-006 SHALL have port mii_rx_er  in  1  PHY receive error.
REQ-007 SHALL have port mii_rxd  in  4  PHY receive nibble, least-significant nibble of each byte first.
REQ-008 SHALL have port data_out  out  9  bit 8 = in-frame flag, bits 7:0 = byte or status.
REQ-009 SHALL have port data_out_vld  out  1  one-cycle strobe qualifying data_out; there is no backpressure.
REQ-010 SHALL have port frame_cnt  out  16  saturating count of terminated frames.
REQ-011 SHALL have port err_cnt  out  16  saturating count of frames with nonzero status.

Function
REQ-012 SHALL implement states IDLE, PREAMBLE, DATA, DROP.
REQ-013 SHALL move IDLE->PREAMBLE when dv=1 and rxd=0x5; IDLE->DROP when dv=1 and rxd is any other value.
REQ-014 SHALL, in PREAMBLE, count 0x5 nibbles saturating at 15; on 0xD with count>=P_MIN_PRE go to DATA, nibble phase cleared.
REQ-015 SHALL, in PREAMBLE, go to DROP on 0xD with count<P_MIN_PRE or on any nibble other than 0x5/0xD; dv=0 returns to IDLE; no output in any of these cases.
REQ-016 SHALL, in DATA, hold the first nibble and on the second form byte {second,first}; stream A,C yields 0xCA.
REQ-017 SHALL drive data_out={1,byte}, data_out_vld=1 in the cycle after the high nibble is sampled (latency 1 clk).
REQ-018 SHALL, in the cycle after the first dv=0 sample in DATA, emit one terminator: data_out={0,status}, data_out_vld=1, then go to IDLE.
REQ-019 SHALL define status bits: bit0 = odd-nibble alignment error, bit1 = rx_er seen in frame, bit2 = length overflow; bits 7:3 = 0.
REQ-020 SHALL set bit0 when dv falls with a held low nibble; the partial nibble is discarded.
REQ-021 SHALL set status bit1 sticky when rx_er=1 while dv=1 in DATA; the nibble is still assembled.
REQ-022 SHALL, when byte P_MAX_BYTES+1 would complete, suppress it, emit the terminator with bit2 set in the next cycle, and go to DROP.
REQ-023 SHALL stay in DROP with no output until dv=0 is sampled, then go to IDLE.
REQ-024 SHALL emit exactly one terminator per frame, including zero-byte frames (SFD then dv=0), which give status 0x00.
REQ-025 SHALL increment frame_cnt on every terminator and err_cnt on every terminator with status!=0, both in the terminator cycle, saturating at 0xFFFF.
REQ-026 SHALL drive data_out=0 whenever data_out_vld=0.

Reset
REQ-027 SHALL, on rst=1, clear state to IDLE, counters, status, nibble phase, byte count, data_out=0, data_out_vld=0.
REQ-028 SHALL, on reset mid-frame, abort with no terminator; a frame in progress at release is resolved by REQ-013/015/023.
REQ-029 SHALL give rst priority over all other inputs in the same cycle.

Structure
REQ-030 SHALL place in shared package eth_rx_pkg: state encoding, PRE=0x5, SFD=0xD, and status bit indices.
REQ-031 SHALL use one sub-module sat_counter (16-bit, increment enable, saturating), instantiated twice.

Verification
REQ-032 SHALL test: 15x0x5, 0xD, nibbles A,C,4,D, dv=0 -> bytes 0x1CA, 0x1D4, terminator 0x000; frame_cnt=1, err_cnt=0.
REQ-033 SHALL test: valid preamble/SFD, 3 nibbles 1,2,3, dv=0 -> byte 0x121, terminator 0x001; err_cnt=1.
REQ-034 SHALL test: rx_er=1 on one nibble of a 2-byte frame -> both bytes output, terminator 0x002.
REQ-035 SHALL test: 1600-byte frame -> 1522 bytes, terminator 0x004, then no output until dv=0.
REQ-036 SHALL test: 2x0x5 then 0xD -> DROP, no output, counters unchanged; a following valid frame is received normally.
REQ-037 SHALL test: rst pulsed mid-frame -> no terminator, counters 0; err_cnt preloaded to 0xFFFF stays 0xFFFF on another bad frame.

Source files
------------

// File: rtl/eth_rx_pkg.sv
// Shared definitions for the MII receive path: FSM encoding, preamble/SFD
// nibble values and the layout of the terminator status byte.
package eth_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } rx_state_e;

    localparam logic [3:0] NIB_PRE = 4'h5;
    localparam logic [3:0] NIB_SFD = 4'hD;

    // Preamble nibble counter saturates here.
    localparam logic [3:0] PRE_CNT_MAX = 4'd15;

    localparam int STAT_ALIGN = 0;
    localparam int STAT_RXER  = 1;
    localparam int STAT_OVFL  = 2;

    function automatic logic [7:0] make_status(input logic align,
                                               input logic rxer,
                                               input logic ovfl);
        logic [7:0] s;
        s             = 8'h00;
        s[STAT_ALIGN] = align;
        s[STAT_RXER]  = rxer;
        s[STAT_OVFL]  = ovfl;
        return s;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous active-high reset; holds at
// all-ones once reached.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples the pre-edge value regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mii_nibble_rx.sv
// MII nibble receiver: strips preamble/SFD, assembles bytes low nibble first,
// and closes every accepted frame with exactly one status terminator.
module mii_nibble_rx
    import eth_rx_pkg::*;
#(
    parameter int P_MIN_PRE   = 4,
    parameter int P_MAX_BYTES = 1522
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mii_rx_dv,
    input  logic        mii_rx_er,
    input  logic [3:0]  mii_rxd,
    output logic [8:0]  data_out,
    output logic        data_out_vld,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
);

    localparam int BC_W = $clog2(P_MAX_BYTES + 1);
    localparam logic [BC_W-1:0] BYTE_LIMIT = BC_W'(P_MAX_BYTES);

    rx_state_e       state, state_n;
    logic [3:0]      pre_cnt, pre_cnt_n;
    logic            phase, phase_n;
    logic [3:0]      low_nib, low_nib_n;
    logic [BC_W-1:0] byte_cnt, byte_cnt_n;
    logic            rxer_seen, rxer_seen_n;
    logic [8:0]      data_out_n;
    logic            data_out_vld_n;
    logic            term;
    logic [7:0]      term_status;
    logic            rxer_now;

    // NOTE: every always_comb target gets a default first, so no path through
    // the case statement can leave a signal unassigned and infer a latch.
    always_comb begin
        state_n        = state;
        pre_cnt_n      = pre_cnt;
        phase_n        = phase;
        low_nib_n      = low_nib;
        byte_cnt_n     = byte_cnt;
        rxer_seen_n    = rxer_seen;
        data_out_n     = '0;
        data_out_vld_n = 1'b0;
        term           = 1'b0;
        term_status    = 8'h00;
        rxer_now       = rxer_seen | mii_rx_er;

        unique case (state)
            ST_IDLE: begin
                if (mii_rx_dv) begin
                    if (mii_rxd == NIB_PRE) begin
                        state_n   = ST_PREAMBLE;
                        pre_cnt_n = 4'd1;
                    end else begin
                        state_n = ST_DROP;
                    end
                end
            end

            ST_PREAMBLE: begin
                if (!mii_rx_dv) begin
                    state_n = ST_IDLE;
                end else if (mii_rxd == NIB_PRE) begin
                    if (pre_cnt != PRE_CNT_MAX) begin
                        pre_cnt_n = pre_cnt + 4'd1;
                    end
                end else if ((mii_rxd == NIB_SFD) && (int'(pre_cnt) >= P_MIN_PRE)) begin
                    state_n     = ST_DATA;
                    phase_n     = 1'b0;
                    byte_cnt_n  = '0;
                    rxer_seen_n = 1'b0;
                end else begin
                    state_n = ST_DROP;
                end
            end

            ST_DATA: begin
                if (!mii_rx_dv) begin
                    // A held low nibble at end of frame is an alignment error.
                    term        = 1'b1;
                    term_status = make_status(phase, rxer_seen, 1'b0);
                    state_n     = ST_IDLE;
                    phase_n     = 1'b0;
                end else begin
                    rxer_seen_n = rxer_now;
                    if (!phase) begin
                        low_nib_n = mii_rxd;
                        phase_n   = 1'b1;
                    end else begin
                        phase_n = 1'b0;
                        if (byte_cnt == BYTE_LIMIT) begin
                            // One byte past the limit: drop it and close the frame.
                            term        = 1'b1;
                            term_status = make_status(1'b0, rxer_now, 1'b1);
                            state_n     = ST_DROP;
                        end else begin
                            data_out_n     = {1'b1, mii_rxd, low_nib};
                            data_out_vld_n = 1'b1;
                            byte_cnt_n     = byte_cnt + 1'b1;
                        end
                    end
                end
            end

            ST_DROP: begin
                if (!mii_rx_dv) begin
                    state_n = ST_IDLE;
                end
            end

            default: state_n = ST_IDLE;
        endcase

        if (term) begin
            data_out_n     = {1'b0, term_status};
            data_out_vld_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            pre_cnt      <= '0;
            phase        <= 1'b0;
            low_nib      <= '0;
            byte_cnt     <= '0;
            rxer_seen    <= 1'b0;
            data_out     <= '0;
            data_out_vld <= 1'b0;
        end else begin
            state        <= state_n;
            pre_cnt      <= pre_cnt_n;
            phase        <= phase_n;
            low_nib      <= low_nib_n;
            byte_cnt     <= byte_cnt_n;
            rxer_seen    <= rxer_seen_n;
            data_out     <= data_out_n;
            data_out_vld <= data_out_vld_n;
        end
    end

    // Counters step on the same edge that registers the terminator.
    sat_counter #(.W(16)) u_frame_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (term),
        .count (frame_cnt)
    );

    sat_counter #(.W(16)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (term && (term_status != 8'h00)),
        .count (err_cnt)
    );

endmodule
